// File: rtl/trace_pkg.sv
// Shared types for the commit trace streamer: record layout, frame length, FSM states, CRC-8 step.
// Build option TRACE_CRC_EN lengthens the frame to 16 bytes (trailing CRC-8).
package trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } trace_rec_t;

`ifdef TRACE_CRC_EN
  localparam int FRAME_LEN = 16;
`else
  localparam int FRAME_LEN = 15;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [7:0] CRC_POLY = 8'h07;

`ifdef TRACE_CRC_EN
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

endpackage

// File: rtl/commit_trace_streamer_if.sv
// Commit bus from the core plus the byte stream toward the UART/debug bridge.
// master = streamer view (consumes commits, drives the stream); slave = core/sink view.
interface commit_trace_streamer_if;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] commit_instr;
  logic        commit_we;
  logic [4:0]  commit_waddr;
  logic [31:0] commit_wdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    input  commit_valid, commit_pc, commit_instr, commit_we, commit_waddr, commit_wdata,
    input  tx_ready,
    output tx_data, tx_valid
  );

  modport slave (
    output commit_valid, commit_pc, commit_instr, commit_we, commit_waddr, commit_wdata,
    output tx_ready,
    input  tx_data, tx_valid
  );
endinterface

// File: rtl/trace_record_fifo.sv
// Synchronous DEPTH-record FIFO; head readable combinationally, push when full succeeds only with a pop.
// Latency: pushed record is at the head one cycle later; full without pop drops the push silently.
module trace_record_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       push,
  input  trace_rec_t push_rec,
  input  logic       pop,
  output trace_rec_t pop_rec,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  trace_rec_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, the slot being popped this cycle is the one the new record lands in.
  assign do_push = push && (!full || do_pop);
  assign pop_rec = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_rec;
  end
endmodule

// File: rtl/commit_trace_streamer.sv
// Captures one record per committed instruction and streams it as a SYNC-framed byte sequence; TRACE_CRC_EN adds a CRC-8 byte.
// Latency: first byte valid 2 edges after the commit when idle; tx_ready low stalls the frame, a full FIFO drops records (counted).
module commit_trace_streamer
  import trace_pkg::*;
#(
  parameter int         DEPTH       = 4,
  parameter int         MAX_RECORDS = 153,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic                            trace_en,
  commit_trace_streamer_if.master         link,
  output logic                            overflow,
  output logic [15:0]                     drop_cnt,
  output logic                            done
);
  state_t       state;
  state_t       state_nxt;
  logic [119:0] shreg;
  logic [3:0]   idx;
  logic [7:0]   seq;
  logic [31:0]  count;
  logic [31:0]  count_eff;
  logic         trace_en_q;
  trace_rec_t   rec_in;
  trace_rec_t   rec_head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic         rise;
  logic         limit_hit;
  logic         cap;
  logic         cap_drop;
  logic         accept;
  logic         last_byte;

  assign rise      = trace_en && !trace_en_q;
  assign count_eff = rise ? 32'd0 : count;
  assign limit_hit = (MAX_RECORDS != 0) && (count_eff >= 32'(MAX_RECORDS));
  assign cap       = link.commit_valid && trace_en && !limit_hit;
  assign cap_drop  = cap && fifo_full && !fifo_pop;
  assign accept    = (state == SEND) && link.tx_ready;
  assign last_byte = (idx == 4'(FRAME_LEN - 1));
  assign rec_in    = {link.commit_pc, link.commit_instr, link.commit_we,
                      link.commit_waddr, link.commit_wdata};

  trace_record_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_in   (clk_in),
    .reset    (reset),
    .push     (cap),
    .push_rec (rec_in),
    .pop      (fifo_pop),
    .pop_rec  (rec_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_nxt     = state;
    fifo_pop      = 1'b0;
    link.tx_valid = 1'b0;
    unique case (state)
      IDLE: if (!fifo_empty) state_nxt = LOAD;
      LOAD: begin
        fifo_pop  = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        link.tx_valid = 1'b1;
        if (link.tx_ready && last_byte) state_nxt = fifo_empty ? IDLE : LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      seq        <= '0;
      count      <= '0;
      trace_en_q <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      trace_en_q <= trace_en;
      // Dropped records still consume the capture budget.
      count      <= cap ? count_eff + 32'd1 : count_eff;
      if (cap_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      if (fifo_pop) begin
        shreg <= {SYNC_BYTE, seq, rec_head.pc, rec_head.instr,
                  rec_head.we, 2'b00, rec_head.waddr, rec_head.wdata};
        idx   <= '0;
      end else if (accept) begin
        shreg <= shreg << 8;
        idx   <= idx + 4'd1;
      end
      if (rise)          seq <= '0;
      else if (fifo_pop) seq <= seq + 8'd1;
      if (rise)                                          done <= 1'b0;
      else if (limit_hit && fifo_empty && state == IDLE) done <= 1'b1;
    end
  end

`ifdef TRACE_CRC_EN
  logic [7:0] crc;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)                     crc <= '0;
    else if (fifo_pop)              crc <= '0;
    else if (accept && !last_byte)  crc <= crc8_step(crc, shreg[119:112]);
  end

  assign link.tx_data = last_byte ? crc : shreg[119:112];
`else
  assign link.tx_data = shreg[119:112];
`endif
endmodule

// File: tb/tb_commit_trace_streamer.sv
// Directed bench for commit_trace_streamer: vector table plus overflow, limit, async-reset sequences.
// Build with TRACE_CRC_EN defined to also check the trailing CRC-8 byte.
module tb_commit_trace_streamer;
`ifdef TRACE_CRC_EN
  localparam int FLEN = 16;
`else
  localparam int FLEN = 15;
`endif

  typedef struct {
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    int           mode;
    logic [119:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ten_a;
  logic        ten_b;
  logic        cv;
  logic [31:0] cpc;
  logic [31:0] cins;
  logic        cwe;
  logic [4:0]  cwa;
  logic [31:0] cwd;
  logic        rdy;
  logic        sel;
  logic        ovf_a;
  logic        ovf_b;
  logic [15:0] drop_a;
  logic [15:0] drop_b;
  logic        done_a;
  logic        done_b;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  fr_bytes [16];
  int          fr_n;
  vec_t        vt [4];

  commit_trace_streamer_if ifa ();
  commit_trace_streamer_if ifb ();

  assign ifa.commit_valid = cv;   assign ifb.commit_valid = cv;
  assign ifa.commit_pc    = cpc;  assign ifb.commit_pc    = cpc;
  assign ifa.commit_instr = cins; assign ifb.commit_instr = cins;
  assign ifa.commit_we    = cwe;  assign ifb.commit_we    = cwe;
  assign ifa.commit_waddr = cwa;  assign ifb.commit_waddr = cwa;
  assign ifa.commit_wdata = cwd;  assign ifb.commit_wdata = cwd;
  assign ifa.tx_ready     = rdy;  assign ifb.tx_ready     = rdy;

  wire       cur_valid = sel ? ifb.tx_valid : ifa.tx_valid;
  wire [7:0] cur_data  = sel ? ifb.tx_data  : ifa.tx_data;

  commit_trace_streamer #(.DEPTH(4), .MAX_RECORDS(153), .SYNC_BYTE(8'hA5)) u_dut (
    .clk_in(clk), .reset(rst_n), .trace_en(ten_a), .link(ifa),
    .overflow(ovf_a), .drop_cnt(drop_a), .done(done_a)
  );

  commit_trace_streamer #(.DEPTH(4), .MAX_RECORDS(3), .SYNC_BYTE(8'hA5)) u_lim (
    .clk_in(clk), .reset(rst_n), .trace_en(ten_b), .link(ifb),
    .overflow(ovf_b), .drop_cnt(drop_b), .done(done_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [119:0] mkframe(input logic [7:0] s, input logic [31:0] pc,
                                           input logic [31:0] ins, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    return {8'hA5, s, pc, ins, we, 2'b00, wa, wd};
  endfunction

`ifdef TRACE_CRC_EN
  function automatic logic [7:0] ref_crc(input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      c = c ^ fr_bytes[i];
      for (int b = 0; b < 8; b++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // Called at a negedge; the commit is sampled on the following posedge.
  task automatic commit1(input logic [31:0] pc, input logic [31:0] ins, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
    cv = 1'b1; cpc = pc; cins = ins; cwe = we; cwa = wa; cwd = wd;
    @(negedge clk);
    cv = 1'b0;
  endtask

  // mode 0: tx_ready held high; mode 1: tx_ready toggles every cycle.
  task automatic collect(input int nwant, input int mode);
    int         cyc;
    logic       pv;
    logic       pr;
    logic [7:0] pd;
    fr_n = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pd = 8'h00;
    while (fr_n < nwant && cyc < 400) begin
      if (pv && !pr) begin
        chk("stall_valid", 32'(cur_valid), 32'd1);
        chk("stall_data", 32'(cur_data), 32'(pd));
      end
      rdy = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (cur_valid && rdy) begin
        fr_bytes[fr_n] = cur_data;
        fr_n++;
      end
      pv = cur_valid; pr = rdy; pd = cur_data;
      @(negedge clk);
      cyc++;
    end
    if (fr_n < nwant) begin
      total++; bad++;
      $display("FAIL collect_timeout: got %0d bytes want %0d", fr_n, nwant);
    end
  endtask

  task automatic chk_frame(input string nm, input logic [119:0] exp);
    chk({nm, "_len"}, 32'(fr_n), 32'(FLEN));
    for (int i = 0; i < 15; i++)
      chk($sformatf("%s_b%0d", nm, i), 32'(fr_bytes[i]), 32'(exp[119-8*i -: 8]));
`ifdef TRACE_CRC_EN
    chk({nm, "_crc"}, 32'(fr_bytes[15]), 32'(ref_crc(15)));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int extra;
    logic [31:0] opc;

    vt[0] = '{32'h0040_0000, 32'h2001_0005, 1'b1, 5'd1,  32'h0000_0005, 0,
              120'hA5_00_00400000_20010005_81_00000005};
    vt[1] = '{32'h0040_0004, 32'h0022_1820, 1'b1, 5'd3,  32'h0000_000A, 1,
              120'hA5_01_00400004_00221820_83_0000000A};
    vt[2] = '{32'h0040_0008, 32'hAC03_0000, 1'b0, 5'd0,  32'hDEAD_BEEF, 1,
              120'hA5_02_00400008_AC030000_00_DEADBEEF};
    vt[3] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF, 0,
              120'hA5_03_FFFFFFFC_FFFFFFFF_9F_FFFFFFFF};

    rst_n = 1'b0; ten_a = 1'b0; ten_b = 1'b0; cv = 1'b0;
    cpc = '0; cins = '0; cwe = 1'b0; cwa = '0; cwd = '0; rdy = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", 32'(ifa.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(ifa.tx_data), 32'd0);
    chk("rst_overflow", 32'(ovf_a), 32'd0);
    chk("rst_drop_cnt", 32'(drop_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    ten_a = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      commit1(vt[v].pc, vt[v].instr, vt[v].we, vt[v].wa, vt[v].wd);
      k = 0;
      while (!cur_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("vec%0d_latency", v), 32'(k), 32'd2);
      collect(FLEN, vt[v].mode);
      chk_frame($sformatf("vec%0d", v), vt[v].exp);
      chk($sformatf("vec%0d_gap", v), 32'(cur_valid), 32'd0);
    end

    // Overflow: park one frame in the shifter so the burst lands entirely on the FIFO.
    rdy = 1'b0;
    commit1(32'h0040_0100, 32'h0000_0013, 1'b0, 5'd0, 32'h0);
    repeat (3) @(negedge clk);
    chk("ovf_parked_valid", 32'(cur_valid), 32'd1);
    ten_a = 1'b0; @(negedge clk);
    ten_a = 1'b1; @(negedge clk);
    for (int i = 0; i < 6; i++)
      commit1(32'h1000_0000 + 32'(i * 4), 32'h00A0_0093 ^ 32'(i), 1'b1, 5'(i + 1), 32'h1111_0000 + 32'(i));
    chk("ovf_flag", 32'(ovf_a), 32'd1);
    chk("ovf_drop_cnt", 32'(drop_a), 32'd2);
    collect(FLEN, 0);
    chk_frame("ovf_parked", mkframe(8'd4, 32'h0040_0100, 32'h0000_0013, 1'b0, 5'd0, 32'h0));
    for (int i = 0; i < 4; i++) begin
      opc = 32'h1000_0000 + 32'(i * 4);
      collect(FLEN, 1);
      chk_frame($sformatf("ovf_q%0d", i),
                mkframe(8'(i), opc, 32'h00A0_0093 ^ 32'(i), 1'b1, 5'(i + 1), 32'h1111_0000 + 32'(i)));
    end
    extra = 0;
    repeat (10) begin
      if (cur_valid) extra++;
      @(negedge clk);
    end
    chk("ovf_no_extra_frame", 32'(extra), 32'd0);
    chk("ovf_drop_kept", 32'(drop_a), 32'd2);

    // Capture limit on the MAX_RECORDS=3 instance.
    ten_a = 1'b0; sel = 1'b1; rdy = 1'b0;
    ten_b = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++)
      commit1(32'h0080_0000 + 32'(i * 4), 32'h0000_0033, 1'b1, 5'd7, 32'(i));
    chk("lim_done_early", 32'(done_b), 32'd0);
    for (int i = 0; i < 3; i++) begin
      collect(FLEN, 0);
      chk_frame($sformatf("lim_f%0d", i),
                mkframe(8'(i), 32'h0080_0000 + 32'(i * 4), 32'h0000_0033, 1'b1, 5'd7, 32'(i)));
    end
    extra = 0;
    repeat (10) begin
      if (cur_valid) extra++;
      @(negedge clk);
    end
    chk("lim_frame_count", 32'(extra), 32'd0);
    chk("lim_done", 32'(done_b), 32'd1);
    chk("lim_no_overflow", 32'(ovf_b), 32'd0);
    ten_b = 1'b0; @(negedge clk);
    chk("lim_done_held", 32'(done_b), 32'd1);
    ten_b = 1'b1; @(negedge clk);
    chk("lim_done_cleared", 32'(done_b), 32'd0);
    commit1(32'h0080_0100, 32'h0000_0033, 1'b1, 5'd9, 32'h99);
    collect(FLEN, 0);
    chk_frame("lim_restart", mkframe(8'd0, 32'h0080_0100, 32'h0000_0033, 1'b1, 5'd9, 32'h99));

    // Asynchronous reset in the middle of a frame, between clock edges.
    ten_b = 1'b0; sel = 1'b0;
    ten_a = 1'b1;
    repeat (2) @(negedge clk);
    commit1(32'h0040_0200, 32'h0000_0013, 1'b0, 5'd0, 32'h0);
    collect(7, 0);
    chk("rstmid_b0", 32'(fr_bytes[0]), 32'hA5);
    chk("rstmid_valid_before", 32'(ifa.tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_tx_valid", 32'(ifa.tx_valid), 32'd0);
    chk("rstmid_overflow", 32'(ovf_a), 32'd0);
    chk("rstmid_drop_cnt", 32'(drop_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    commit1(32'h0040_0300, 32'h0123_4567, 1'b1, 5'd2, 32'hCAFE_F00D);
    collect(FLEN, 0);
    chk_frame("rstmid_next", mkframe(8'd0, 32'h0040_0300, 32'h0123_4567, 1'b1, 5'd2, 32'hCAFE_F00D));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/commit_trace_streamer.md
Name: commit_trace_streamer

Overview:
Hardware-side producer of the per-instruction commit trace for the single-cycle CPU: pc, instr, register write-back. Sits beside the CPU core inside the top-level computer wrapper. Captures one record per committed instruction into a small record FIFO. Serializes each record as a framed byte stream over a valid/ready link to a UART or debug bridge, so board runs yield the same trace content as simulation.

Parameters:
DEPTH, 4, record FIFO depth in records; power of two, at least 2.
MAX_RECORDS, 153, records captured after trace_en rises; 0 means unlimited.
SYNC_BYTE, 8'hA5, frame header byte.

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset
trace_en  input  1  capture enable; rising edge restarts the record count
commit_valid  input  1  one instruction commits this cycle
commit_pc  input  32  pc of the committing instruction
commit_instr  input  32  instruction word
commit_we  input  1  register-file write enable
commit_waddr  input  5  destination register
commit_wdata  input  32  write-back data
tx_data  output  8  stream byte
tx_valid  output  1  tx_data valid
tx_ready  input  1  sink accepts the byte
overflow  output  1  sticky: at least one record was dropped
drop_cnt  output  16  dropped-record count, saturating
done  output  1  MAX_RECORDS captured and the stream is drained

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, FSM=IDLE, tx_valid=0, tx_data=0, overflow=0, drop_cnt=0, done=0, seq=0, capture count=0.
- Capture: a record is taken on a clk_in edge when commit_valid=1, trace_en=1, and the capture limit is not reached (count<MAX_RECORDS, or MAX_RECORDS=0).
  - If the FIFO is not full, the record is pushed and count increments.
  - If the FIFO is full, the record is accepted only when the FSM pops in the same cycle. Otherwise it is dropped: overflow is set, drop_cnt increments (saturates at 16'hFFFF), and count still increments.
- Rising edge of trace_en clears count, seq and done. It does not clear overflow or drop_cnt, and does not flush the FIFO.
- Frame: 15 bytes, in this order: SYNC_BYTE, seq[7:0], pc[31:24..7:0], instr[31:24..7:0], {commit_we,2'b00,waddr}, wdata[31:24..7:0].
  - Multi-byte fields are big-endian.
  - seq increments per emitted frame and wraps 255->0.
- FSM states: IDLE, LOAD, SEND.
  - IDLE->LOAD when the FIFO is non-empty.
  - LOAD: pop the head into a 120-bit shift register and set byte index=0. Takes 1 cycle; tx_valid=0.
  - SEND: tx_valid=1 and tx_data=current byte. On tx_valid&tx_ready, advance the index. After the last byte is accepted, go to LOAD if the FIFO is non-empty, else IDLE.
  - Minimum gap between frames: 1 cycle.
- Handshake: tx_data is stable while tx_valid=1 and tx_ready=0. tx_valid never drops before acceptance. tx_ready may be high at any time, including while tx_valid=0, with no effect.
- Frame latency: commit on edge N puts the first byte valid after edge N+2, when the FIFO is empty and the FSM is IDLE.
- done=1 when the limit is reached, the FIFO is empty and the FSM is IDLE. It stays 1 until the next trace_en rise or reset.
- trace_en falling mid-frame: the current frame and the queued records still drain.
- Reset mid-frame: the frame is truncated and the sink resynchronises on SYNC_BYTE.

Optional Feature:
TRACE_CRC_EN.
- Defined: a 16th byte is appended to every frame. It is CRC-8, polynomial 0x07, init 0x00, computed over bytes 1..15 (header included), and updated per accepted byte.
- Undefined: the frame is 15 bytes and no CRC logic is present.
- Frame length must come from a package constant so the FSM is unchanged either way.

Decomposition:
- Package trace_pkg holds:
  - the record struct (pc, instr, we, waddr, wdata; 102 bits);
  - the frame-length constant (15/16 under TRACE_CRC_EN);
  - the FSM state enum;
  - the CRC polynomial.
- One sub-module: trace_record_fifo, a synchronous FIFO of DEPTH records with push, pop, full and empty, and the simultaneous push-and-pop-when-full rule. The CRC stays inline.

Test Plan:
- Single record with tx_ready tied 1: pc=0x00400000, instr=0x20010005, we=1, waddr=1, wdata=5 -> bytes A5 00 00 40 00 00 20 01 00 05 81 00 00 00 05; first byte 2 cycles after commit.
- Backpressure: tx_ready toggles 1/0 every cycle -> tx_data holds while stalled; exactly 15 accepted bytes; no duplicate or skipped byte.
- Overflow: DEPTH=4, tx_ready=0, 6 consecutive commits -> first 4 queued, then overflow=1, drop_cnt=2; releasing tx_ready yields 4 frames with seq 0..3.
- Limit: MAX_RECORDS=3, 5 commits -> 3 frames; done=1 after the last byte; a trace_en re-rise clears done and seq restarts at 0.
- Asynchronous reset asserted mid-frame (byte 7) without a clock edge -> tx_valid=0, overflow=0 and drop_cnt=0 immediately; the next commit emits a frame with seq=00.
- TRACE_CRC_EN defined, the same record as scenario 1 -> 16 bytes; the last byte equals the reference CRC-8 of the first 15 bytes.
